// File: rtl/apple_iie_timing_pkg.sv
// Shared timing constants for the IIe timing generator, video scanner and MMU bench.
// Tick indices are positions within one phi0 cycle of 14M ticks.
package apple_iie_timing_pkg;

    localparam logic [3:0] TICK_PHI0_RISE = 4'd7;
    localparam logic [3:0] TICK_RAS_A     = 4'd2;
    localparam logic [3:0] TICK_RAS_B     = 4'd9;
    localparam logic [3:0] TICK_CAS_A     = 4'd4;
    localparam logic [3:0] TICK_CAS_B     = 4'd11;
    localparam logic [3:0] TICK_LDPS      = 4'd13;
    localparam logic [3:0] TICK_LAST      = 4'd13;

    localparam int DEFAULT_CYCLES_PER_LINE  = 65;
    localparam int DEFAULT_LINES_PER_FRAME  = 262;
    localparam int DEFAULT_LONG_CYCLE_EXTRA = 2;

    typedef struct packed {
        logic phi0;
        logic q3;
        logic pras_n;
        logic pcas_n;
        logic ldps_n;
    } cycle_pins_t;

    // Ticks past TICK_LAST only occur in the long cycle and extend the final low/high phases.
    function automatic cycle_pins_t decode_tick(input logic [3:0] t);
        cycle_pins_t p;
        p.phi0   = (t >= TICK_PHI0_RISE);
        p.q3     = (t < TICK_CAS_A) || ((t >= TICK_PHI0_RISE) && (t < TICK_CAS_B));
        p.pras_n = !(((t >= TICK_RAS_A) && (t < TICK_PHI0_RISE)) || (t >= TICK_RAS_B));
        p.pcas_n = !(((t >= TICK_CAS_A) && (t < TICK_PHI0_RISE)) || (t >= TICK_CAS_B));
        p.ldps_n = (t != TICK_LDPS);
        return p;
    endfunction

endpackage

// File: rtl/apple_iie_video_counter.sv
// Horizontal/vertical video counters, advanced once per phi0 cycle.
// long_cycle is registered from the next hcount so it lines up with the cycle it describes.
module apple_iie_video_counter
    import apple_iie_timing_pkg::*;
#(
    parameter int CYCLES_PER_LINE = DEFAULT_CYCLES_PER_LINE,
    parameter int LINES_PER_FRAME = DEFAULT_LINES_PER_FRAME
) (
    input  logic       clk_14m,
    input  logic       reset,
    input  logic       advance,
    output logic [6:0] hcount,
    output logic [8:0] vcount,
    output logic       long_cycle
);

    localparam logic [6:0] H_LAST = 7'(CYCLES_PER_LINE - 1);
    localparam logic [8:0] V_LAST = 9'(LINES_PER_FRAME - 1);

    logic [6:0] hcount_next;
    logic [8:0] vcount_next;
    logic       line_end;

    always_comb begin
        hcount_next = hcount;
        vcount_next = vcount;
        line_end    = advance && (hcount >= H_LAST);
        if (advance) begin
            hcount_next = line_end ? 7'd0 : hcount + 7'd1;
        end
        if (line_end) begin
            vcount_next = (vcount >= V_LAST) ? 9'd0 : vcount + 9'd1;
        end
    end

    always_ff @(posedge clk_14m) begin
        if (reset) begin
            hcount     <= 7'd0;
            vcount     <= 9'd0;
            long_cycle <= 1'b0;
        end else begin
            hcount     <= hcount_next;
            vcount     <= vcount_next;
            long_cycle <= (hcount_next == H_LAST);
        end
    end

endmodule

// File: rtl/apple_iie_timing_generator.sv
// Single-clock IIe timing HAL: phi0/q3/RAS/CAS/LDPS, 7M and colour reference, video counters.
// Every pin is registered from the decode of the tick being entered.
module apple_iie_timing_generator
    import apple_iie_timing_pkg::*;
#(
    parameter int CYCLES_PER_LINE  = DEFAULT_CYCLES_PER_LINE,
    parameter int LINES_PER_FRAME  = DEFAULT_LINES_PER_FRAME,
    parameter int LONG_CYCLE_EXTRA = DEFAULT_LONG_CYCLE_EXTRA
) (
    input  logic       clk_14m,
    input  logic       reset,
    output logic       clk_phi_0,
    output logic       clk_phi_1,
    output logic       clk_q3,
    output logic       pras_n,
    output logic       pcas_n,
    output logic       clk_7m,
    output logic       color_ref,
    output logic       ldps_n,
    output logic       phi0_rise,
    output logic       phi0_fall,
    output logic [6:0] hcount,
    output logic [8:0] vcount,
    output logic       long_cycle
);

    localparam logic [3:0] TICK_LAST_LONG = 4'(TICK_LAST + LONG_CYCLE_EXTRA);

    logic [3:0]  tick;
    logic [3:0]  tick_next;
    logic [3:0]  last_tick;
    logic        started;
    logic        cycle_end;
    logic [1:0]  color_cnt;
    cycle_pins_t pins_next;

    // The first edge out of reset re-enters tick 0 rather than advancing, so no cycle is shortened.
    always_comb begin
        last_tick = long_cycle ? TICK_LAST_LONG : TICK_LAST;
        cycle_end = started && (tick >= last_tick);
        tick_next = (!started || (tick >= last_tick)) ? 4'd0 : tick + 4'd1;
        pins_next = decode_tick(tick_next);
    end

    always_ff @(posedge clk_14m) begin
        if (reset) begin
            tick      <= 4'd0;
            started   <= 1'b0;
            color_cnt <= 2'd0;
            clk_phi_0 <= 1'b0;
            clk_phi_1 <= 1'b1;
            clk_q3    <= 1'b1;
            pras_n    <= 1'b1;
            pcas_n    <= 1'b1;
            ldps_n    <= 1'b1;
            phi0_rise <= 1'b0;
            phi0_fall <= 1'b0;
        end else begin
            tick      <= tick_next;
            started   <= 1'b1;
            color_cnt <= color_cnt + 2'd1;
            clk_phi_0 <= pins_next.phi0;
            clk_phi_1 <= !pins_next.phi0;
            clk_q3    <= pins_next.q3;
            pras_n    <= pins_next.pras_n;
            pcas_n    <= pins_next.pcas_n;
            ldps_n    <= pins_next.ldps_n;
            phi0_rise <= (tick_next == TICK_PHI0_RISE);
            phi0_fall <= (tick_next == 4'd0) && clk_phi_0;
        end
    end

    // The colour counter never follows the tick wrap; the 912-tick line keeps it phase-locked.
    assign clk_7m    = color_cnt[0];
    assign color_ref = color_cnt[1];

    apple_iie_video_counter #(
        .CYCLES_PER_LINE(CYCLES_PER_LINE),
        .LINES_PER_FRAME(LINES_PER_FRAME)
    ) u_video_counter (
        .clk_14m   (clk_14m),
        .reset     (reset),
        .advance   (cycle_end),
        .hcount    (hcount),
        .vcount    (vcount),
        .long_cycle(long_cycle)
    );

endmodule
